// File: rtl/gnr_pkg.sv
// gnr_pkg: shared definitions for the GNR gene-node datapath.
//   - mode encodings for the node update rule
//   - th_width(): signed width needed to hold popcount(act) - popcount(inh)
//   - popcount(): population count over a zero-extended vector (up to POPCNT_W bits)
package gnr_pkg;

  typedef enum logic [1:0] {
    MODE_AND    = 2'd0,
    MODE_OR     = 2'd1,
    MODE_THRESH = 2'd2,
    MODE_HOLD   = 2'd3
  } gnr_mode_e;

  localparam int POPCNT_W = 32;

  // Room for +/-N_IN: magnitude bits plus one sign bit.
  function automatic int th_width(input int n_in);
    return $clog2(n_in + 1) + 1;
  endfunction

  function automatic int unsigned popcount(input logic [POPCNT_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int k = 0; k < POPCNT_W; k++) begin
      n += 32'(v[k]);
    end
    return n;
  endfunction

endpackage

// File: rtl/gnr_node_param_if.sv
// gnr_node_param_if: control/data bundle between the network scheduler,
// neighbouring nodes and one gnr_node_param instance.
//   master : scheduler side (drives re-init, steps, inputs, rule config; reads state)
//   slave  : node side
// Signals:
//   reset_nos  synchronous network re-init      init_state per-copy init value
//   start_s    per-copy step pulse               in_s       regulator states, copy c at [c*N_IN +: N_IN]
//   mask_act   activator mask                    mask_inh   inhibitor mask (wins over mask_act)
//   mode       rule select (gnr_mode_e values)   threshold  signed THRESH limit
//   delay      skipped steps between updates     s/changed/stable  node outputs per copy
interface gnr_node_param_if
  import gnr_pkg::*;
#(
  parameter int N_IN    = 4,
  parameter int N_CH    = 2,
  parameter int DELAY_W = 4,
  parameter int TH_W    = th_width(N_IN)
);

  logic                     reset_nos;
  logic [N_CH-1:0]          init_state;
  logic [N_CH-1:0]          start_s;
  logic [N_CH*N_IN-1:0]     in_s;
  logic [N_IN-1:0]          mask_act;
  logic [N_IN-1:0]          mask_inh;
  logic [1:0]               mode;
  logic signed [TH_W-1:0]   threshold;
  logic [DELAY_W-1:0]       delay;
  logic [N_CH-1:0]          s;
  logic [N_CH-1:0]          changed;
  logic [N_CH-1:0]          stable;

  modport master (
    output reset_nos, init_state, start_s, in_s, mask_act, mask_inh, mode, threshold, delay,
    input  s, changed, stable
  );

  modport slave (
    input  reset_nos, init_state, start_s, in_s, mask_act, mask_inh, mode, threshold, delay,
    output s, changed, stable
  );

endinterface

// File: rtl/gnr_node_eval.sv
// gnr_node_eval: combinational next-state rule for one node copy.
// Ports:
//   in_v       regulator states for this copy
//   mask_act   activator mask; mask_inh inhibitor mask (inhibitor wins on overlap)
//   mode       MODE_AND / MODE_OR / MODE_THRESH / MODE_HOLD
//   threshold  signed limit for MODE_THRESH
//   cur        current state of this copy (returned in MODE_HOLD)
//   next       evaluated next state
module gnr_node_eval
  import gnr_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int TH_W = th_width(N_IN)
) (
  input  logic [N_IN-1:0]        in_v,
  input  logic [N_IN-1:0]        mask_act,
  input  logic [N_IN-1:0]        mask_inh,
  input  logic [1:0]             mode,
  input  logic signed [TH_W-1:0] threshold,
  input  logic                   cur,
  output logic                   next
);

  logic [N_IN-1:0]        act_eff;
  logic [N_IN-1:0]        a_v;
  logic [N_IN-1:0]        i_v;
  logic signed [TH_W-1:0] pc_a;
  logic signed [TH_W-1:0] pc_i;
  logic signed [TH_W-1:0] diff;
  logic                   and_act;

  // An input flagged in both masks counts only as an inhibitor.
  assign act_eff = mask_act & ~mask_inh;
  assign a_v     = in_v & act_eff;
  assign i_v     = in_v & mask_inh;

  // Non-activator positions are forced to 1, so AND with no activators is true.
  assign and_act = &(in_v | ~act_eff);

  // TH_W holds +/-N_IN, so the subtraction cannot overflow.
  assign pc_a = TH_W'(popcount(POPCNT_W'(a_v)));
  assign pc_i = TH_W'(popcount(POPCNT_W'(i_v)));
  assign diff = pc_a - pc_i;

  always_comb begin
    next = cur;
    case (mode)
      MODE_AND:    next = and_act & ~(|i_v);
      MODE_OR:     next = (|a_v) & ~(|i_v);
      MODE_THRESH: next = (diff >= threshold);
      default:     next = cur;
    endcase
  end

endmodule

// File: rtl/gnr_node_param.sv
// gnr_node_param: N_CH independent copies of one Boolean-network gene node.
// Each copy evaluates its rule (gnr_node_eval) and updates on start_s[c],
// gated by a per-copy step-skip down-counter reloaded from delay.
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous reset, active-high
//   bus   gnr_node_param_if.slave (re-init, steps, inputs, config, s/changed/stable)
// Build option:
//   GNR_STABLE_DETECT_EN  defined   -> per-copy run counters drive stable
//                         undefined -> stable tied to 0
module gnr_node_param
  import gnr_pkg::*;
#(
  parameter int N_IN         = 4,
  parameter int N_CH         = 2,
  parameter int DELAY_W      = 4,
  parameter int STABLE_LIMIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  gnr_node_param_if.slave  bus
);

  localparam int TH_W = th_width(N_IN);

  if (N_IN < 1 || N_IN > POPCNT_W) begin : g_bad_n_in
    $error("gnr_node_param: N_IN must be in 1..%0d", POPCNT_W);
  end
  if (STABLE_LIMIT < 1) begin : g_bad_limit
    $error("gnr_node_param: STABLE_LIMIT must be >= 1");
  end

  logic [N_CH-1:0]               s_q;
  logic [N_CH-1:0]               changed_q;
  logic [N_CH-1:0]               next_s;
  logic [N_CH-1:0][DELAY_W-1:0]  cnt;

  for (genvar c = 0; c < N_CH; c++) begin : g_eval
    gnr_node_eval #(
      .N_IN (N_IN),
      .TH_W (TH_W)
    ) u_eval (
      .in_v      (bus.in_s[c*N_IN +: N_IN]),
      .mask_act  (bus.mask_act),
      .mask_inh  (bus.mask_inh),
      .mode      (bus.mode),
      .threshold (bus.threshold),
      .cur       (s_q[c]),
      .next      (next_s[c])
    );
  end

  // cnt==0 means the next step performs an update; delay is only sampled then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q       <= '0;
      changed_q <= '0;
      cnt       <= '0;
    end else if (bus.reset_nos) begin
      s_q       <= bus.init_state;
      changed_q <= '0;
      cnt       <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        changed_q[c] <= 1'b0;
        if (bus.start_s[c]) begin
          if (cnt[c] == '0) begin
            s_q[c]       <= next_s[c];
            cnt[c]       <= bus.delay;
            changed_q[c] <= next_s[c] ^ s_q[c];
          end else begin
            cnt[c] <= cnt[c] - DELAY_W'(1);
          end
        end
      end
    end
  end

  assign bus.s       = s_q;
  assign bus.changed = changed_q;

`ifdef GNR_STABLE_DETECT_EN
  localparam int RUN_W = $clog2(STABLE_LIMIT + 1);
  localparam logic [RUN_W-1:0] RUN_LIM = RUN_W'(STABLE_LIMIT);

  logic [N_CH-1:0][RUN_W-1:0] run;
  logic [N_CH-1:0][RUN_W-1:0] run_nxt;
  logic [N_CH-1:0]            stable_q;

  // Only performed updates touch run; skipped steps leave it alone.
  always_comb begin
    run_nxt = run;
    for (int c = 0; c < N_CH; c++) begin
      if (bus.start_s[c] && (cnt[c] == '0)) begin
        if (next_s[c] != s_q[c]) begin
          run_nxt[c] = '0;
        end else if (run[c] < RUN_LIM) begin
          run_nxt[c] = run[c] + RUN_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run      <= '0;
      stable_q <= '0;
    end else if (bus.reset_nos) begin
      run      <= '0;
      stable_q <= '0;
    end else begin
      run <= run_nxt;
      for (int c = 0; c < N_CH; c++) begin
        stable_q[c] <= (run_nxt[c] >= RUN_LIM);
      end
    end
  end

  assign bus.stable = stable_q;
`else
  assign bus.stable = '0;
`endif

endmodule
